uart_prog_loader: RTL

Serial program loader for the 4-bit CPU board. It receives 8N1 UART bytes on a single `rx` pin and writes a program image into the program RAM through the RAM write port. It holds the CPU in reset while an image is loading and releases it when the last byte is written. It sits upstream of the RAM and CPU, at the board top, running on the fast board clock rather than the divided CPU clock.

---
 rtl/loader_pkg.sv | 9 +
 rtl/uart_rx.sv | 77 +++++++
 rtl/uart_prog_loader.sv | 81 ++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared state encodings and constants for the serial program loader.
package loader_pkg;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic {RUN, LOAD} ld_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: rx synchronizer, bit timer and framing FSM.
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2 - 1;

    rx_state_t     state, nstate;
    logic [1:0]    sync;
    logic          rx_s, rx_prev, bit_end;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    assign rx_s    = sync[1];
    assign bit_end = (state == R_START) ? (cnt == CW'(HALF)) : (cnt == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        nstate = state;
        case (state)
            R_IDLE:  if (rx_prev && !rx_s) nstate = R_START;
            R_START: if (bit_end) nstate = rx_s ? R_IDLE : R_DATA;
            R_DATA:  if (bit_end && bit_idx == 3'd7) nstate = R_STOP;
            R_STOP:  if (bit_end) nstate = R_IDLE;
            default: nstate = R_IDLE;
        endcase
    end

    // Synchronizer and edge-detect flops reset to the idle-high line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= R_IDLE;
            sync     <= 2'b11;
            rx_prev  <= 1'b1;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            state    <= nstate;
            sync     <= {sync[0], rx};
            rx_prev  <= rx_s;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            cnt      <= (state == R_IDLE || bit_end) ? '0 : cnt + 1'b1;
            case (state)
                R_START: if (bit_end) bit_idx <= '0;
                R_DATA: if (bit_end) begin
                    shreg   <= {rx_s, shreg[7:1]};
                    bit_idx <= bit_idx + 1'b1;
                end
                R_STOP: if (bit_end) begin
                    if (rx_s) begin
                        rx_valid <= 1'b1;
                        rx_data  <= shreg;
                    end else begin
                        rx_ferr <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Loads a DEPTH-byte program image from UART into program RAM, holding
// the CPU in reset for the duration of the load.
module uart_prog_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234,
    parameter int DEPTH        = 16,
    parameter int TIMEOUT_CYC  = 2_700_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       we,
    output logic [7:0] w_addr,
    output logic [7:0] w_data,
    output logic       cpu_rst_n,
    output logic       loading,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    ld_state_t     state, nstate;
    logic [7:0]    rx_data, addr;
    logic          rx_valid, rx_ferr, tmo_hit, last_we;
    logic [TW-1:0] tmo;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr)
    );

    assign tmo_hit = (tmo == TW'(TIMEOUT_CYC - 1));
    assign last_we = we && (w_addr == 8'(DEPTH - 1));
    assign loading = (state == LOAD);

    // A byte arriving on the expiry cycle wins over the timeout.
    always_comb begin
        nstate = state;
        case (state)
            RUN:  if (rx_valid && rx_data == SYNC_BYTE) nstate = LOAD;
            LOAD: if (last_we || (tmo_hit && !rx_valid)) nstate = RUN;
            default: nstate = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            addr      <= '0;
            tmo       <= '0;
            we        <= 1'b0;
            w_addr    <= '0;
            w_data    <= '0;
            cpu_rst_n <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= nstate;
            cpu_rst_n <= (nstate == RUN);
            we        <= 1'b0;
            if (rx_ferr) frame_err <= 1'b1;
            if (state == RUN) begin
                addr <= '0;
                tmo  <= '0;
            end else begin
                tmo <= rx_valid ? '0 : tmo + 1'b1;
                if (rx_valid && !last_we) begin
                    we     <= 1'b1;
                    w_addr <= addr;
                    w_data <= rx_data;
                    addr   <= addr + 1'b1;
                end
            end
        end
    end

endmodule
